// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//
// Handshaked execute-stage ALU. Single-cycle operations are computed
// combinationally and registered. MUL/DIVU/REMU iterate one bit per cycle for
// WIDTH cycles. Divide by zero skips the iteration.
//
// Optional feature (macro ALU_OVERFLOW_FLAG_EN):
//   When defined, the extra output `overflow` flags signed overflow of add and
//   subtract. It is registered together with ALU_result.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. The producer holds its data stable while valid is high and ready is
//   low. The unit takes one operation at a time. in_ready is high only in IDLE
//   and out_valid is high only in DONE, so an output transfer and a new input
//   transfer never happen in the same cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    operands/control_in valid
//   in_ready    unit can accept an operation (registered, high in IDLE)
//   Rd1         operand A
//   Rd2_or_Imm  operand B (register or immediate)
//   control_in  4-bit operation select
//   out_valid   ALU_result/zero valid (registered, high in DONE)
//   out_ready   consumer accepts the result
//   ALU_result  registered result
//   zero        registered, 1 when ALU_result == 0
//   busy        high while iterating (CALC)
//   overflow    [ALU_OVERFLOW_FLAG_EN only] signed add/sub overflow
//   state_dbg   current FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module alu_seq_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] Rd1,
   input  logic [WIDTH-1:0] Rd2_or_Imm,
   input  logic [3:0]       control_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_result,
   output logic             zero,
   output logic             busy,
`ifdef ALU_OVERFLOW_FLAG_EN
   output logic             overflow,
`endif
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;
   localparam logic [3:0] OP_REMU = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         op_q;
   // acc_q: product accumulator (MUL) or partial remainder (DIVU/REMU).
   // opa_q: multiplicand shifting left (MUL) or dividend/quotient (DIVU/REMU).
   // opb_q: multiplier shifting right (MUL) or divisor (DIVU/REMU).
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;

   // ---------------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------------
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   sc_result;
   logic               is_iter;
   logic               div_zero;

   always_comb begin
      shamt     = Rd2_or_Imm[SHAMT_W-1:0];
      sum       = Rd1 + Rd2_or_Imm;
      diff      = Rd1 - Rd2_or_Imm;
      sc_result = '0;
      case (control_in)
         OP_AND:  sc_result = Rd1 & Rd2_or_Imm;
         OP_OR:   sc_result = Rd1 | Rd2_or_Imm;
         OP_ADD:  sc_result = sum;
         OP_SUB:  sc_result = diff;
         OP_XOR:  sc_result = Rd1 ^ Rd2_or_Imm;
         OP_SLL:  sc_result = Rd1 << shamt;
         OP_SRL:  sc_result = Rd1 >> shamt;
         OP_SRA:  sc_result = $unsigned($signed(Rd1) >>> shamt);
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(Rd1) < $signed(Rd2_or_Imm))};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (Rd1 < Rd2_or_Imm)};
         // These two values are only used on the divide-by-zero bypass.
         OP_DIVU: sc_result = '1;
         OP_REMU: sc_result = Rd1;
         default: sc_result = '0;
      endcase
      is_iter  = (control_in == OP_MUL) || (control_in == OP_DIVU) || (control_in == OP_REMU);
      div_zero = ((control_in == OP_DIVU) || (control_in == OP_REMU)) && (Rd2_or_Imm == '0);
   end

`ifdef ALU_OVERFLOW_FLAG_EN
   logic sc_ovf;
   always_comb begin
      sc_ovf = 1'b0;
      if (control_in == OP_ADD)
         sc_ovf = (Rd1[WIDTH-1] == Rd2_or_Imm[WIDTH-1]) && (sum[WIDTH-1] != Rd1[WIDTH-1]);
      else if (control_in == OP_SUB)
         sc_ovf = (Rd1[WIDTH-1] != Rd2_or_Imm[WIDTH-1]) && (diff[WIDTH-1] != Rd1[WIDTH-1]);
   end
`endif

   // ---------------------------------------------------------------------------
   // Iterative step (one bit per cycle)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] mul_acc_nx;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic             div_take;
   logic [WIDTH-1:0] div_rem_nx;
   logic [WIDTH-1:0] div_quo_nx;
   logic [WIDTH-1:0] iter_result;

   always_comb begin
      mul_acc_nx = acc_q + (opb_q[0] ? opa_q : '0);
      // Restoring division: shift the next dividend bit into the remainder and
      // try to subtract the divisor. The partial remainder stays below the
      // divisor, so a non-negative trial never sets the top bit.
      div_shift  = {acc_q, opa_q[WIDTH-1]};
      div_trial  = div_shift - {1'b0, opb_q};
      div_take   = ~div_trial[WIDTH];
      div_rem_nx = div_take ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_quo_nx = {opa_q[WIDTH-2:0], div_take};
      case (op_q)
         OP_MUL:  iter_result = mul_acc_nx;
         OP_DIVU: iter_result = div_quo_nx;
         default: iter_result = div_rem_nx;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         ALU_result <= '0;
         zero       <= 1'b1;
         cnt        <= '0;
         op_q       <= '0;
         acc_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
`ifdef ALU_OVERFLOW_FLAG_EN
         overflow   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (is_iter && !div_zero) begin
                     op_q  <= control_in;
                     acc_q <= '0;
                     opa_q <= Rd1;
                     opb_q <= Rd2_or_Imm;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= S_CALC;
                  end else begin
                     ALU_result <= sc_result;
                     zero       <= (sc_result == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
                     overflow   <= sc_ovf;
`endif
                     out_valid  <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end
            S_CALC: begin
               cnt <= cnt + 1'b1;
               if (op_q == OP_MUL) begin
                  acc_q <= mul_acc_nx;
                  opa_q <= opa_q << 1;
                  opb_q <= opb_q >> 1;
               end else begin
                  acc_q <= div_rem_nx;
                  opa_q <= div_quo_nx;
               end
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  ALU_result <= iter_result;
                  zero       <= (iter_result == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
                  overflow   <= 1'b0;
`endif
                  busy       <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
//
// Directed and random operations go through a driver task. At acceptance the
// expected result, latency and busy-cycle count are queued. A monitor on the
// falling edge compares every presented output against the queue head and pops
// it on the output handshake.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

   localparam int W  = 32;
   localparam int SH = $clog2(W);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;
   localparam logic [3:0] OP_REMU = 4'b1100;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] Rd1;
   logic [W-1:0] Rd2_or_Imm;
   logic [3:0]   control_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ALU_result;
   logic         zero;
   logic         busy;
   logic         overflow;
   logic [1:0]   state_dbg;

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Rd1        (Rd1),
      .Rd2_or_Imm (Rd2_or_Imm),
      .control_in (control_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALU_result (ALU_result),
      .zero       (zero),
      .busy       (busy),
`ifdef ALU_OVERFLOW_FLAG_EN
      .overflow   (overflow),
`endif
      .state_dbg  (state_dbg)
   );

`ifndef ALU_OVERFLOW_FLAG_EN
   assign overflow = 1'b0;
`endif

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   bit           ovf_q[$];
   int           lat_q[$];
   int           busy_q[$];
   int           acc_q[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit prev_ov = 1'b0;
   int busy_cnt = 0;
   int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [SH-1:0]    sh;
      logic [2*W-1:0]   prod;
      logic [W-1:0]     r;
      sh   = b[SH-1:0];
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0011: r = a ^ b;
         4'b0100: r = a << sh;
         4'b0101: r = a >> sh;
         4'b0111: begin
            r = a >> sh;
            if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
         end
         4'b1000: r = (W'(signed'(a) < signed'(b)));
         4'b1001: r = (W'(a < b));
         4'b1010: r = prod[W-1:0];
         4'b1011: r = (b == 0) ? {W{1'b1}} : a / b;
         4'b1100: r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic bit ref_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, r, lim;
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      lim = longint'(1) <<< (W - 1);
      if (op == OP_ADD)      r = sa + sb;
      else if (op == OP_SUB) r = sa - sb;
      else                   return 1'b0;
      return (r >= lim) || (r < -lim);
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
      if (op == OP_MUL) return W + 1;
      if ((op == OP_DIVU || op == OP_REMU) && b != 0) return W + 1;
      return 1;
   endfunction

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'($urandom_range(0, 20));
         3:       return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r);
      exp_q.push_back(exp_r);
      ovf_q.push_back(ref_ovf(op, a, b));
      lat_q.push_back(ref_lat(op, b));
      busy_q.push_back(ref_lat(op, b) - 1);
      acc_q.push_back(cyc);
   endtask

   // Call one step after a rising edge. Holds the operation until accepted,
   // then scrambles the operand bus so later changes must not matter.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r);
      int n;
      n          = 0;
      control_in = op;
      Rd1        = a;
      Rd2_or_Imm = b;
      in_valid   = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         push_exp(op, a, b, exp_r);
         @(posedge clk); #1;
         in_valid   = 1'b0;
         Rd1        = W'($urandom);
         Rd2_or_Imm = W'($urandom);
         control_in = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic issue_rand();
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = pick_val();
      b  = pick_val();
      issue(op, a, b, ref_result(op, a, b));
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- out_ready driver ----------------
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (busy) begin
            busy_cnt++;
            check("busy_ready_valid", {62'd0, in_ready, out_valid}, 64'd0);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 64'd1, 64'd0);
            end else begin
               check("result", 64'(ALU_result), 64'(exp_q[0]));
               check("zero", 64'(zero), 64'(exp_q[0] == '0));
               check("in_ready_in_done", 64'(in_ready), 64'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
               check("overflow", 64'(overflow), 64'(ovf_q[0]));
`endif
               if (!prev_ov) begin
                  check("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
                  check("busy_cycles", 64'(busy_cnt), 64'(busy_q[0]));
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  void'(ovf_q.pop_front());
                  void'(lat_q.pop_front());
                  void'(busy_q.pop_front());
                  void'(acc_q.pop_front());
                  busy_cnt = 0;
               end
            end
         end
         prev_ov = out_valid;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      reset      = 1'b1;
      in_valid   = 1'b1;   // held through reset on purpose
      control_in = OP_ADD;
      Rd1        = 32'd3;
      Rd2_or_Imm = 32'd4;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values, with in_valid still high.
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(ALU_result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      mon_en = 1'b1;
      push_exp(OP_ADD, 32'd3, 32'd4, 32'd7);
      @(posedge clk); #1;
      in_valid = 1'b0;

      // Directed operations from the plan.
      issue(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
      issue(OP_SUB,  32'd5,         32'd5,         32'h0000_0000);
      issue(OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
      issue(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      issue(OP_MUL,  32'h0001_2345, 32'h0001_0000, 32'h2345_0000);
      issue(OP_DIVU, 32'd100,       32'd7,         32'd14);
      issue(OP_REMU, 32'd100,       32'd7,         32'd2);
      issue(OP_DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF);
      issue(OP_REMU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
      issue(OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF);
      issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);
      drain(200);

      // Backpressure: hold the result in DONE for 5 cycles.
      rdy_mode  = 2;
      out_ready = 1'b0;
      issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_result", 64'(ALU_result), 64'h00F0_1234);
         @(negedge clk);
      end
      rdy_mode = 0;
      @(posedge clk); #1;
      drain(50);

      // Reset in the middle of a DIVU: nothing may come out.
      issue(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0013, 32'hDEAD_BEEF / 32'h13);
      repeat (9) @(posedge clk);
      #1;
      check("mid_busy_before_reset", 64'(busy), 64'd1);
      reset  = 1'b1;
      mon_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete(); ovf_q.delete(); lat_q.delete(); busy_q.delete(); acc_q.delete();
      busy_cnt = 0;
      prev_ov  = 1'b0;
      @(negedge clk);
      check("mr_state", 64'(state_dbg), 64'd0);
      check("mr_in_ready", 64'(in_ready), 64'd1);
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_result", 64'(ALU_result), 64'd0);
      check("mr_zero", 64'(zero), 64'd1);
      for (int i = 0; i < W + 4; i++) begin
         if (out_valid) check("mr_out_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      check("mr_out_valid_end", 64'(out_valid), 64'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;
      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      drain(200);

      // Random operations with random backpressure.
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) issue_rand();
      rdy_mode = 0;
      drain(500);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #2000000;
      errors++;
      $display("FAIL global_timeout: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Supports the existing AND/OR/add/subtract encodings plus XOR, shifts, set-less-than, and iterative multiply/divide/remainder.
- Single-cycle ops are registered. MUL/DIVU/REMU run through an internal state machine over WIDTH cycles.
- Sits in the execute stage. Valid/ready on both sides lets a future multi-cycle or pipelined core stall on it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHAMT_W, $clog2(WIDTH), number of low bits of operand B used as shift amount.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and control_in are valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- Rd1  input  WIDTH  operand A.
- Rd2_or_Imm  input  WIDTH  operand B (register or immediate).
- control_in  input  4  operation select.
- out_valid  output  1  ALU_result and zero are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- ALU_result  output  WIDTH  registered result.
- zero  output  1  registered; 1 when ALU_result == 0.
- busy  output  1  high in CALC state.

Behaviour:
- Encodings (4 bits):
  - 0000 AND, 0001 OR, 0010 add, 0110 subtract (unchanged from the current ALU).
  - 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 MUL (low WIDTH bits of product), 1011 DIVU, 1100 REMU.
  - All other codes produce result 0.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH.
  - Shifts use Rd2_or_Imm[SHAMT_W-1:0] only.
  - SLT/SLTU result is {WIDTH-1 zeros, flag}.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Handshake is in_valid && in_ready.
  - Single-cycle op: compute and register the result, go to DONE. out_valid is asserted the cycle after acceptance (latency 1).
  - MUL/DIVU/REMU: latch operands, clear the iteration counter, go to CALC.
- CALC:
  - in_ready=0, busy=1.
  - MUL: one shift-add step per cycle.
  - DIVU/REMU: one restoring-division step per cycle.
  - After exactly WIDTH steps, register the result and go to DONE. out_valid first high WIDTH+1 cycles after acceptance.
- Divide by zero (B==0 at acceptance):
  - Bypass CALC and go straight to DONE (latency 1).
  - DIVU result = all ones; REMU result = Rd1.
- DONE:
  - out_valid=1; ALU_result and zero held stable while out_ready=0.
  - When out_ready=1, go to IDLE. No new operation is accepted in the same cycle (in_ready=0 in DONE).
- zero is always computed from the registered result and updates together with ALU_result.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ALU_result=0, zero=1, counter=0.
- Reset mid-operation (CALC or DONE): operation discarded, all outputs return to reset values on the next edge. No partial result is ever presented.
- in_valid while in_ready=0 is ignored. Operand changes during CALC have no effect.

Optional Feature:
- Macro: ALU_OVERFLOW_FLAG_EN.
- Defined:
  - Extra output port overflow (1 bit), registered alongside the result.
  - Set to signed overflow for add (A,B same sign, result sign differs) and subtract (A,B differ in sign, result sign differs from A).
  - 0 for all other ops; reset value 0.
- Undefined: port absent, no overflow logic.

Test Plan:
- Reset with in_valid=1 held -> after reset deasserts: out_valid=0, ALU_result=0, zero=1, in_ready=1; first accepted op completes normally.
- add 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid one cycle later, result 0x80000000, zero=0; overflow=1 if macro defined. subtract 5-5 -> result 0, zero=1.
- SRA 0x80000000 by B=0x00000024 (shamt 4) -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTU on the same operands -> 0.
- MUL 0x00012345 * 0x00010000 -> busy for 32 cycles, out_valid at cycle 33, result 0x23450000. DIVU 100/7 -> 14; REMU 100/7 -> 2; same latency.
- DIVU 0x1234 / 0 -> out_valid at cycle 1, result 0xFFFFFFFF. REMU 0x1234 / 0 -> 0x00001234.
- Backpressure and reset: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Then assert reset at cycle 10 of a DIVU -> out_valid never rises and state returns to IDLE.
